// File: rtl/dvi_rx_pkg.sv
// dvi_rx_pkg: shared state encoding and parameter limits for the dvi_rx line reader.
package dvi_rx_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, READ = ST_READ, DRAIN = ST_DRAIN} state_t;
  localparam int RD_LATENCY_MIN    = 1;
  localparam int RD_LATENCY_MAX    = 2;
  localparam int FIFO_DEPTH_MARGIN = 1;
  function automatic bit params_ok(input int rd_latency, input int fifo_depth);
    return rd_latency >= RD_LATENCY_MIN && rd_latency <= RD_LATENCY_MAX &&
           fifo_depth >= rd_latency + FIFO_DEPTH_MARGIN;
  endfunction
endpackage

// File: rtl/line_reader_fifo.sv
// line_reader_fifo: first-word fall-through sync FIFO with flush; a push into an empty FIFO is visible the same cycle.
module line_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic empty, write, read;
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  // a word pushed and popped in the same cycle while empty never touches the array
  assign write = push && !(empty && pop);
  assign read  = pop && !empty;
  assign valid = !empty || push;
  assign dout  = !empty ? mem[rd_ptr] : (push ? din : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (write) wr_ptr <= next_ptr(wr_ptr);
      if (read) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(write) - CW'(read);
    end
  end
  always_ff @(posedge clk)
    if (write) mem[wr_ptr] <= din;
endmodule

// File: rtl/ram_line_reader.sv
// ram_line_reader: streams len words from the line RAM starting at base_addr, with
// credit-limited read issue so the output FIFO never overflows under backpressure.
module ram_line_reader import dvi_rx_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  abort,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  if (!params_ok(RD_LATENCY, FIFO_DEPTH)) begin : g_param_check
    $error("ram_line_reader: RD_LATENCY must be 1..2 and FIFO_DEPTH >= RD_LATENCY+1");
  end
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0] len_q, issued, out_cnt;
  logic [RD_LATENCY-1:0] vp;
  logic [FCW-1:0] fifo_count;
  logic [CW-1:0] credit;
  logic accept, re_nxt, hs;
  assign accept = state == IDLE && start && !abort;
  assign hs     = o_valid && i_ready;
  assign busy   = state != IDLE;
  assign o_last = o_valid && out_cnt == len_q - ONE;
  // words already owed to the FIFO: stored, registered re, and RAM pipeline
  always_comb begin
    credit = CW'(fifo_count) + CW'(ram_re);
    for (int i = 0; i < RD_LATENCY; i++) credit = credit + CW'(vp[i]);
  end
  assign re_nxt = !abort && (accept ? len != '0 :
                  state == READ && issued < len_q && credit < CW'(FIFO_DEPTH));
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else if (accept) state_nxt = len != '0 ? READ : IDLE;
    else if (state == READ && issued == len_q) state_nxt = DRAIN;
    else if (state != IDLE && hs && o_last) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_re    <= 1'b0;
      ram_raddr <= '0;
      vp        <= '0;
      done      <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      issued    <= '0;
      out_cnt   <= '0;
    end else begin
      ram_re <= re_nxt;
      vp     <= abort ? '0 : RD_LATENCY'({vp, ram_re});
      done   <= !abort && ((accept && len == '0) || (state != IDLE && hs && o_last));
      if (re_nxt) ram_raddr <= accept ? base_addr : base_q + issued[ADDR_WIDTH-1:0];
      if (accept) begin
        base_q  <= base_addr;
        len_q   <= len;
        issued  <= len != '0 ? ONE : '0;
        out_cnt <= '0;
      end else begin
        issued <= issued + (ADDR_WIDTH+1)'(re_nxt);
        if (hs) out_cnt <= out_cnt + ONE;
      end
    end
  end
  line_reader_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(abort),
    .push(vp[RD_LATENCY-1]),
    .din(ram_rdata),
    .pop(hs),
    .valid(o_valid),
    .dout(o_data),
    .count(fifo_count)
  );
endmodule
